test_mod3: RTL and testbench

Serial divisible-by-3 detector. It consumes one bit per clock on din, MSB first, and tracks the remainder modulo 3 of the binary number accumulated since reset. dout flags when that accumulated number is a multiple of 3. It is a standalone streaming checker that sits on any single-bit serial data path.

---
 rtl/test_mod3_if.sv | 16 +
 rtl/test_mod3.sv | 44 ++++
 tb/tb_test_mod3.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/test_mod3_if.sv
// Serial bit-stream bundle for the divisible-by-3 detector.
// din: serial data bit (MSB first); dout: registered divisible-by-3 flag.
interface test_mod3_if;
    logic din;
    logic dout;

    modport master (
        output din,
        input  dout
    );

    modport slave (
        input  din,
        output dout
    );
endinterface

// File: rtl/test_mod3.sv
// Serial divisible-by-3 detector: tracks value mod 3, MSB first.
// Ports: clk, rst_n (async active-low), bus.din in, bus.dout out.
module test_mod3 (
    input  logic         clk,
    input  logic         rst_n,
    test_mod3_if.slave   bus
);

    typedef enum logic [1:0] {
        S0   = 2'b00,
        S1   = 2'b01,
        S2   = 2'b10,
        SBAD = 2'b11
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   dout_q;

    // Remainder update: next = (2*R + din) mod 3.
    always_comb begin
        state_nxt = S0;
        unique case (state)
            S0:      state_nxt = bus.din ? S1 : S0;
            S1:      state_nxt = bus.din ? S0 : S2;
            S2:      state_nxt = bus.din ? S2 : S1;
            default: state_nxt = S0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S0;
            dout_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            // Flag reflects the bit taken on this same edge.
            dout_q <= (state_nxt == S0);
        end
    end

    assign bus.dout = dout_q;

endmodule

// File: tb/tb_test_mod3.sv
// Self-checking bench for test_mod3 using a mod-3 arithmetic model.
// Covers reset, directed streams, rotating pattern and random bits.
module tb_test_mod3;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   rem;

    test_mod3_if bus ();

    test_mod3 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b exp=%b t=%0t", tag, got, exp, $time);
        end
    endtask

    // Present one bit, let it be sampled, then compare against the model.
    task automatic feed(input bit b, input string tag);
        bus.din = b;
        @(posedge clk);
        #1;
        rem = (rem * 2 + int'(b)) % 3;
        chk(tag, bus.dout, rem == 0);
    endtask

    // Same as feed, plus a check against a value fixed by hand.
    task automatic feed_exp(input bit b, input bit exp, input string tag);
        feed(b, tag);
        chk({tag, "_fixed"}, bus.dout, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_async", bus.dout, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rem = 0;
    endtask

    // Pulse reset between edges; dout must clear with no clock edge.
    task automatic pulse_reset(input string tag);
        #1;
        rst_n = 1'b0;
        #1;
        chk(tag, bus.dout, 1'b0);
        #1;
        rst_n = 1'b1;
        rem = 0;
    endtask

    logic [23:0] pat;
    bit          b;

    initial begin
        total   = 0;
        bad     = 0;
        rem     = 0;
        rst_n   = 1'b0;
        bus.din = 1'b0;
        pat     = 24'hA59549;

        // 1: reset held, din toggling, dout low without any clock
        #1;
        chk("rst_t0", bus.dout, 1'b0);
        repeat (4) begin
            @(posedge clk);
            #1;
            bus.din = ~bus.din;
            chk("rst_hold", bus.dout, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        rem = 0;

        // 2: 1,1,0 -> 0,1,1
        feed_exp(1'b1, 1'b0, "s110_0");
        feed_exp(1'b1, 1'b1, "s110_1");
        feed_exp(1'b0, 1'b1, "s110_2");

        // 3: 0xA5 -> only last edge flags
        do_reset();
        for (int i = 7; i >= 0; i--) begin
            b = (8'hA5 >> i) & 1;
            feed_exp(b, (i == 0), "sA5");
        end

        // 4: rotating 24-bit pattern, 120 bits
        do_reset();
        for (int i = 0; i < 120; i++) begin
            b = pat[23 - (i % 24)];
            feed(b, "rot");
        end

        // 5: leading zeros then a one
        do_reset();
        feed_exp(1'b0, 1'b1, "zero0");
        feed_exp(1'b0, 1'b1, "zero1");
        feed_exp(1'b0, 1'b1, "zero2");
        feed_exp(1'b1, 1'b0, "zero_one");

        // 6: mid-stream reset with R=S2, then 1,1 -> 0,1
        do_reset();
        feed_exp(1'b1, 1'b0, "mid_a");
        feed_exp(1'b0, 1'b0, "mid_b");
        pulse_reset("mid_rst");
        feed_exp(1'b1, 1'b0, "mid_c");
        feed_exp(1'b1, 1'b1, "mid_d");

        // Reset pulse while dout is high must clear it immediately
        pulse_reset("hi_rst");
        feed(1'b0, "after_hi_rst");

        // Random stream with occasional mid-stream reset pulses
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0)
                pulse_reset("rnd_rst");
            b = 1'($urandom_range(0, 1));
            feed(b, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
